io_check_multi: RTL and testbench

- Multi-channel, pipelined I/O readiness checker for the memory-mapped I/O port banks.
- Each of CHANNEL_COUNT operand channels supplies an address, e.g. two read operands and one write destination.
- The block decides whether each address hits an I/O port and masks that port's Empty/Full bit against a per-channel ready state.
- It combines the results into one instruction-level ready, emits one-hot per-port access strobes only when every channel is ready, and tracks per-channel stall counts for debug.

---
 rtl/io_check_multi_if.sv | 31 +++
 rtl/io_check_multi.sv | 146 ++++++++++++++
 tb/tb_io_check_multi.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_check_multi_if.sv
// Bus bundle for io_check_multi: one access request per cycle in, annotated
// readiness/strobe/debug results out.
//   in_valid, addr, port_EF               : requester -> checker
//   out_valid, addr_is_IO, channel_ready,
//   all_ready, port_strobe, stall_count   : checker -> requester
interface io_check_multi_if #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned CHANNEL_COUNT = 3,
    parameter int unsigned PORT_COUNT    = 4,
    parameter int unsigned STALL_WIDTH   = 8
);
    logic                                   in_valid;
    logic [CHANNEL_COUNT*ADDR_WIDTH-1:0]    addr;
    logic [CHANNEL_COUNT*PORT_COUNT-1:0]    port_EF;
    logic                                   out_valid;
    logic [CHANNEL_COUNT-1:0]               addr_is_IO;
    logic [CHANNEL_COUNT-1:0]               channel_ready;
    logic                                   all_ready;
    logic [CHANNEL_COUNT*PORT_COUNT-1:0]    port_strobe;
    logic [CHANNEL_COUNT*STALL_WIDTH-1:0]   stall_count;

    modport master (
        output in_valid, addr, port_EF,
        input  out_valid, addr_is_IO, channel_ready, all_ready, port_strobe, stall_count
    );

    modport slave (
        input  in_valid, addr, port_EF,
        output out_valid, addr_is_IO, channel_ready, all_ready, port_strobe, stall_count
    );
endinterface

// File: rtl/io_check_multi.sv
// Multi-channel pipelined I/O readiness checker.
// Each channel address is decoded against the I/O port window; a hit selects
// that port's Empty/Full bit, which is compared with the channel's ready
// polarity. The instruction is ready only when every channel is ready, and
// only then are one-hot port strobes issued. Latency is 2 + EXTRA_STAGES.
// Ports:
//   clock, reset : sole clock, synchronous active-high reset
//   bus (slave)  : in_valid/addr/port_EF in; out_valid, addr_is_IO,
//                  channel_ready, all_ready, port_strobe, stall_count out
module io_check_multi #(
    parameter int unsigned               ADDR_WIDTH     = 10,
    parameter int unsigned               CHANNEL_COUNT  = 3,
    parameter int unsigned               PORT_COUNT     = 4,
    parameter int unsigned               PORT_BASE_ADDR = 0,
    parameter logic [CHANNEL_COUNT-1:0]  READY_STATE    = CHANNEL_COUNT'(3'b011),
    parameter int unsigned               EXTRA_STAGES   = 0,
    parameter int unsigned               STALL_WIDTH    = 8
) (
    input  logic             clock,
    input  logic             reset,
    io_check_multi_if.slave  bus
);
    localparam int unsigned C     = CHANNEL_COUNT;
    localparam int unsigned P     = PORT_COUNT;
    localparam int unsigned SW    = STALL_WIDTH;
    localparam int unsigned IDX_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    localparam int unsigned CTL_W = 2 + 2 * C;  // {valid, hit[C], ready[C], all}
    localparam int unsigned STB_W = C * P;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(PORT_BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(PORT_COUNT);
    localparam logic [SW-1:0]         STALL_MAX = '1;

    // Address decode: a borrow out of (addr - base) means below the window,
    // which keeps low addresses from wrapping into a hit.
    logic [C-1:0]     hit_c;
    logic [STB_W-1:0] onehot_c;
    logic [C-1:0]     ef_sel_c;

    for (genvar c = 0; c < C; c++) begin : g_dec
        logic [ADDR_WIDTH:0]   diff;
        logic [IDX_W-1:0]      idx;
        assign diff       = {1'b0, bus.addr[c*ADDR_WIDTH +: ADDR_WIDTH]} - {1'b0, BASE};
        assign hit_c[c]   = !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < SPAN);
        assign idx        = IDX_W'(diff[ADDR_WIDTH-1:0]);
        for (genvar p = 0; p < P; p++) begin : g_port
            assign onehot_c[c*P + p] = hit_c[c] && (idx == IDX_W'(p));
        end
        assign ef_sel_c[c] = |(onehot_c[c*P +: P] & bus.port_EF[c*P +: P]);
    end

    // Stage 1: registered decode results.
    logic             v1_q;
    logic [C-1:0]     hit1_q;
    logic [STB_W-1:0] oh1_q;
    logic [C-1:0]     ef1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q   <= 1'b0;
            hit1_q <= '0;
            oh1_q  <= '0;
            ef1_q  <= '0;
        end else begin
            v1_q   <= bus.in_valid;
            hit1_q <= hit_c;
            oh1_q  <= onehot_c;
            ef1_q  <= ef_sel_c;
        end
    end

    // Stage 2 inputs: memory accesses are always ready; everything masked by valid.
    logic [C-1:0]     rdy_c;
    logic             all_c;
    logic [CTL_W-1:0] ctl_s2_c;
    logic [STB_W-1:0] stb_s2_c;

    assign rdy_c    = ~hit1_q | ~(ef1_q ^ READY_STATE);
    assign all_c    = v1_q && (&rdy_c);
    assign ctl_s2_c = {v1_q, {C{v1_q}} & hit1_q, {C{v1_q}} & rdy_c, all_c};
    assign stb_s2_c = {STB_W{all_c}} & oh1_q;

    // Stage 2 register followed by EXTRA_STAGES plain delay registers.
    logic [CTL_W-1:0] ctl_q [EXTRA_STAGES+1];
    logic [STB_W-1:0] stb_q [EXTRA_STAGES+1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i <= EXTRA_STAGES; i++) begin
                ctl_q[i] <= '0;
                stb_q[i] <= '0;
            end
        end else begin
            ctl_q[0] <= ctl_s2_c;
            stb_q[0] <= stb_s2_c;
            for (int unsigned i = 1; i <= EXTRA_STAGES; i++) begin
                ctl_q[i] <= ctl_q[i-1];
                stb_q[i] <= stb_q[i-1];
            end
        end
    end

    // Control word about to enter the output stage; the stall counters update
    // on the same edge so they stay aligned with the visible output cycle.
    logic [CTL_W-1:0] fin_ctl_c;

    if (EXTRA_STAGES == 0) begin : g_fin0
        assign fin_ctl_c = ctl_s2_c;
    end else begin : g_finn
        assign fin_ctl_c = ctl_q[EXTRA_STAGES-1];
    end

    logic         fin_valid_c;
    logic [C-1:0] fin_hit_c;
    logic [C-1:0] fin_rdy_c;
    logic         fin_all_c;

    assign fin_valid_c = fin_ctl_c[CTL_W-1];
    assign fin_hit_c   = fin_ctl_c[CTL_W-2 -: C];
    assign fin_rdy_c   = fin_ctl_c[C:1];
    assign fin_all_c   = fin_ctl_c[0];

    // Consecutive-stall counters: clear on a completed instruction, saturate.
    logic [C*SW-1:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (fin_valid_c) begin
            for (int unsigned c = 0; c < C; c++) begin
                if (fin_all_c) begin
                    stall_q[c*SW +: SW] <= '0;
                end else if (fin_hit_c[c] && !fin_rdy_c[c] &&
                             (stall_q[c*SW +: SW] != STALL_MAX)) begin
                    stall_q[c*SW +: SW] <= stall_q[c*SW +: SW] + SW'(1);
                end
            end
        end
    end

    assign bus.out_valid     = ctl_q[EXTRA_STAGES][CTL_W-1];
    assign bus.addr_is_IO    = ctl_q[EXTRA_STAGES][CTL_W-2 -: C];
    assign bus.channel_ready = ctl_q[EXTRA_STAGES][C:1];
    assign bus.all_ready     = ctl_q[EXTRA_STAGES][0];
    assign bus.port_strobe   = stb_q[EXTRA_STAGES];
    assign bus.stall_count   = stall_q;
endmodule

// File: tb/tb_io_check_multi.sv
// Directed bench for io_check_multi: base 0x200, 3 channels x 4 ports,
// READY_STATE 3'b011. dut0 has latency 2, dut1 (EXTRA_STAGES=2) latency 4;
// both see identical stimulus.
module tb_io_check_multi;
    localparam int unsigned AW = 10;
    localparam int unsigned CC = 3;
    localparam int unsigned PC = 4;
    localparam int unsigned SW = 8;

    typedef struct {
        logic [CC*AW-1:0] addr;
        logic [CC*PC-1:0] ef;
        logic [CC-1:0]    hit;
        logic [CC-1:0]    rdy;
        logic             all;
        logic [CC*PC-1:0] stb;
        logic [CC*SW-1:0] stall;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [CC*AW-1:0] addr;
    logic [CC*PC-1:0] ef;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    io_check_multi_if #(.ADDR_WIDTH(AW), .CHANNEL_COUNT(CC), .PORT_COUNT(PC), .STALL_WIDTH(SW)) bus0 ();
    io_check_multi_if #(.ADDR_WIDTH(AW), .CHANNEL_COUNT(CC), .PORT_COUNT(PC), .STALL_WIDTH(SW)) bus1 ();

    assign bus0.in_valid = in_valid;
    assign bus0.addr     = addr;
    assign bus0.port_EF  = ef;
    assign bus1.in_valid = in_valid;
    assign bus1.addr     = addr;
    assign bus1.port_EF  = ef;

    io_check_multi #(
        .ADDR_WIDTH(AW), .CHANNEL_COUNT(CC), .PORT_COUNT(PC), .PORT_BASE_ADDR(32'h200),
        .READY_STATE(3'b011), .EXTRA_STAGES(0), .STALL_WIDTH(SW)
    ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    io_check_multi #(
        .ADDR_WIDTH(AW), .CHANNEL_COUNT(CC), .PORT_COUNT(PC), .PORT_BASE_ADDR(32'h200),
        .READY_STATE(3'b011), .EXTRA_STAGES(2), .STALL_WIDTH(SW)
    ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic get_out(input int d, output logic ov, output logic [CC-1:0] h,
                           output logic [CC-1:0] r, output logic a,
                           output logic [CC*PC-1:0] s, output logic [CC*SW-1:0] st);
        if (d == 0) begin
            ov = bus0.out_valid; h = bus0.addr_is_IO; r = bus0.channel_ready;
            a = bus0.all_ready;  s = bus0.port_strobe; st = bus0.stall_count;
        end else begin
            ov = bus1.out_valid; h = bus1.addr_is_IO; r = bus1.channel_ready;
            a = bus1.all_ready;  s = bus1.port_strobe; st = bus1.stall_count;
        end
    endtask

    task automatic check_vec(input string tag, input int d, input vec_t v);
        logic ov, a;
        logic [CC-1:0] h, r;
        logic [CC*PC-1:0] s;
        logic [CC*SW-1:0] st;
        get_out(d, ov, h, r, a, s, st);
        chk({tag, ".out_valid"},  32'(ov), 32'(1'b1));
        chk({tag, ".addr_is_IO"}, 32'(h),  32'(v.hit));
        chk({tag, ".ready"},      32'(r),  32'(v.rdy));
        chk({tag, ".all_ready"},  32'(a),  32'(v.all));
        chk({tag, ".strobe"},     32'(s),  32'(v.stb));
        chk({tag, ".stall"},      32'(st), 32'(v.stall));
    endtask

    // Single isolated access: checks dut0 at +2, dut1 at +4, and idle slots around them.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clock);
        in_valid = 1'b1; addr = v.addr; ef = v.ef;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        check_vec({tag, ".d0"}, 0, v);
        chk({tag, ".d1.early"}, 32'(bus1.out_valid), 32'(1'b0));
        @(negedge clock);
        chk({tag, ".d0.after"}, 32'(bus0.out_valid), 32'(1'b0));
        chk({tag, ".d1.early3"}, 32'(bus1.out_valid), 32'(1'b0));
        @(negedge clock);
        check_vec({tag, ".d1"}, 1, v);
    endtask

    task automatic check_b2b(input int d, input int k);
        logic ov, a;
        logic [CC-1:0] h, r;
        logic [CC*PC-1:0] s;
        logic [CC*SW-1:0] st;
        string tag;
        tag = $sformatf("b2b.d%0d.k%0d", d, k);
        get_out(d, ov, h, r, a, s, st);
        if (k < 8) begin
            chk({tag, ".out_valid"}, 32'(ov), 32'(1'b1));
            chk({tag, ".all_ready"}, 32'(a),  (k % 2 == 0) ? 32'h1 : 32'h0);
            chk({tag, ".strobe"},    32'(s),  (k % 2 == 0) ? 32'h004 : 32'h0);
            chk({tag, ".stall"},     32'(st), (k % 2 == 0) ? 32'h0 : 32'h1);
        end else begin
            chk({tag, ".out_valid"}, 32'(ov), 32'(1'b0));
            chk({tag, ".strobe"},    32'(s),  32'h0);
            chk({tag, ".stall"},     32'(st), 32'h1);
        end
    endtask

    function automatic vec_t mkv(input logic [AW-1:0] a2, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a0, input logic [CC*PC-1:0] e,
                                 input logic [CC-1:0] h, input logic [CC-1:0] r,
                                 input logic a, input logic [CC*PC-1:0] s,
                                 input logic [CC*SW-1:0] st);
        vec_t v;
        v.addr = {a2, a1, a0}; v.ef = e; v.hit = h; v.rdy = r;
        v.all = a; v.stb = s; v.stall = st;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [10];
        vec_t v;
        //              a2      a1      a0      ef       hit     rdy     all   stb      stall
        vecs[0] = mkv(10'h012, 10'h011, 10'h010, 12'h000, 3'b000, 3'b111, 1'b1, 12'h000, 24'h000000);
        vecs[1] = mkv(10'h011, 10'h010, 10'h202, 12'h004, 3'b001, 3'b111, 1'b1, 12'h004, 24'h000000);
        vecs[2] = mkv(10'h011, 10'h010, 10'h202, 12'h000, 3'b001, 3'b110, 1'b0, 12'h000, 24'h000001);
        vecs[3] = mkv(10'h011, 10'h010, 10'h202, 12'h000, 3'b001, 3'b110, 1'b0, 12'h000, 24'h000002);
        vecs[4] = mkv(10'h000, 10'h204, 10'h1FF, 12'hFFF, 3'b000, 3'b111, 1'b1, 12'h000, 24'h000000);
        vecs[5] = mkv(10'h200, 10'h203, 10'h200, 12'h081, 3'b111, 3'b111, 1'b1, 12'h181, 24'h000000);
        vecs[6] = mkv(10'h203, 10'h011, 10'h010, 12'h800, 3'b100, 3'b011, 1'b0, 12'h000, 24'h010000);
        vecs[7] = mkv(10'h203, 10'h202, 10'h201, 12'h840, 3'b111, 3'b010, 1'b0, 12'h000, 24'h020001);
        vecs[8] = mkv(10'h201, 10'h201, 10'h201, 12'h022, 3'b111, 3'b111, 1'b1, 12'h222, 24'h000000);
        vecs[9] = mkv(10'h201, 10'h201, 10'h201, 12'hD2D, 3'b111, 3'b110, 1'b0, 12'h000, 24'h000001);

        // Reset with a would-strobe access held on in_valid: it must be ignored.
        reset = 1'b1; in_valid = 1'b1; addr = vecs[5].addr; ef = vecs[5].ef;
        repeat (3) @(negedge clock);
        chk("rst.d0.out_valid", 32'(bus0.out_valid),   32'h0);
        chk("rst.d0.strobe",    32'(bus0.port_strobe), 32'h0);
        chk("rst.d0.stall",     32'(bus0.stall_count), 32'h0);
        chk("rst.d1.out_valid", 32'(bus1.out_valid),   32'h0);
        chk("rst.d1.stall",     32'(bus1.stall_count), 32'h0);
        reset = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("rst_ign.d0.k%0d", k), 32'(bus0.out_valid), 32'h0);
            chk($sformatf("rst_ign.d1.k%0d", k), 32'(bus1.out_valid), 32'h0);
        end

        for (int i = 0; i < 10; i++) apply($sformatf("v%0d", i), vecs[i]);

        // Write channel stalling back-to-back for 300 cycles: saturate at 255.
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            in_valid = 1'b1; addr = {10'h203, 10'h011, 10'h010}; ef = 12'h800;
        end
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("sat.d0.stall", 32'(bus0.stall_count), 32'hFF0001);
        chk("sat.d1.stall", 32'(bus1.stall_count), 32'hFF0001);

        v = mkv(10'h203, 10'h011, 10'h010, 12'h000, 3'b100, 3'b111, 1'b1, 12'h800, 24'h000000);
        apply("sat_clr", v);

        // Back-to-back alternating ready / not-ready on ch0.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clock);
                    in_valid = 1'b1; addr = {10'h011, 10'h010, 10'h202};
                    ef = (k % 2 == 0) ? 12'h004 : 12'h000;
                end
                @(negedge clock);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clock);
                for (int k = 0; k < 9; k++) begin
                    check_b2b(0, k);
                    if (k < 8) @(negedge clock);
                end
            end
            begin
                repeat (5) @(negedge clock);
                for (int k = 0; k < 9; k++) begin
                    check_b2b(1, k);
                    if (k < 8) @(negedge clock);
                end
            end
        join

        // Reset one cycle after an access: it must vanish and counters clear.
        @(negedge clock);
        in_valid = 1'b1; addr = vecs[5].addr; ef = vecs[5].ef;
        @(negedge clock);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst.d0.out_valid", 32'(bus0.out_valid),   32'h0);
        chk("midrst.d0.strobe",    32'(bus0.port_strobe), 32'h0);
        chk("midrst.d0.stall",     32'(bus0.stall_count), 32'h0);
        chk("midrst.d1.stall",     32'(bus1.stall_count), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("midrst.d0.k%0d", k), 32'(bus0.out_valid), 32'h0);
            chk($sformatf("midrst.d1.k%0d", k), 32'(bus1.out_valid), 32'h0);
        end
        apply("post_rst", vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
